// File: rtl/sc_csai_seq.sv
// rtl/sc_csai_seq.sv - program-counter sequencer with INC/JMP/BRANCH/CALL/RET and a LIFO return stack.
// Optional macro CSAI_SEQ_STACK_WRAP_EN: CALL on a full stack overwrites the oldest entry instead of flagging an error.
module sc_csai_seq #(
  parameter int DATAWIDTH_BUS_CSAI_SEQ = 11,
  parameter int CSAI_SEQ_STEP          = 1,
  parameter int CSAI_SEQ_STACK_DEPTH   = 4,
  parameter int CSAI_SEQ_RESET_VECTOR  = 0
) (
  input  logic                              SC_CSAI_SEQ_CLOCK_50,
  input  logic                              SC_CSAI_SEQ_RESET_InHigh,
  input  logic                              CSAI_SEQ_STALL_In,
  input  logic [2:0]                        CSAI_SEQ_OP_In,
  input  logic [DATAWIDTH_BUS_CSAI_SEQ-1:0] CSAI_SEQ_TARGET_In,
  output logic [DATAWIDTH_BUS_CSAI_SEQ-1:0] CSAI_SEQ_PC_Out,
  output logic [DATAWIDTH_BUS_CSAI_SEQ-1:0] CSAI_SEQ_LINK_Out,
  output logic                              CSAI_SEQ_STACK_EMPTY_Out,
  output logic                              CSAI_SEQ_STACK_FULL_Out,
  output logic                              CSAI_SEQ_ERROR_Out
);

  localparam int W  = DATAWIDTH_BUS_CSAI_SEQ;
  localparam int D  = CSAI_SEQ_STACK_DEPTH;
  localparam int CW = $clog2(D + 1);
  localparam int PW = $clog2(D);

  localparam logic [W-1:0]  STEP_W  = W'(CSAI_SEQ_STEP);
  localparam logic [W-1:0]  RST_W   = W'(CSAI_SEQ_RESET_VECTOR);
  localparam logic [CW-1:0] DEPTH_C = CW'(D);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [PW-1:0] PTR_ONE = PW'(1);
  localparam logic [PW-1:0] PTR_MAX = PW'(D - 1);

  localparam logic [2:0] OP_JMP    = 3'b001;
  localparam logic [2:0] OP_BRANCH = 3'b010;
  localparam logic [2:0] OP_CALL   = 3'b011;
  localparam logic [2:0] OP_RET    = 3'b100;

  logic [W-1:0]  pc_q, pc_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic          empty_q, empty_d;
  logic          full_q, full_d;
  logic          error_q, error_d;
  logic [W-1:0]  stack_q [D];
  logic [W-1:0]  stack_d [D];

  logic [W-1:0]  link;
  logic [PW-1:0] ptr_inc, ptr_dec;

  // ptr_q is the next free slot; the stack is a ring so wrap mode can overwrite the oldest entry
  assign link    = pc_q + STEP_W;
  assign ptr_inc = (ptr_q == PTR_MAX) ? '0 : ptr_q + PTR_ONE;
  assign ptr_dec = (ptr_q == '0) ? PTR_MAX : ptr_q - PTR_ONE;

  always_comb begin
    pc_d    = pc_q;
    count_d = count_q;
    ptr_d   = ptr_q;
    error_d = error_q;
    stack_d = stack_q;
    if (!CSAI_SEQ_STALL_In) begin
      case (CSAI_SEQ_OP_In)
        OP_JMP:    pc_d = CSAI_SEQ_TARGET_In;
        OP_BRANCH: pc_d = pc_q + CSAI_SEQ_TARGET_In;
        OP_CALL: begin
          pc_d = CSAI_SEQ_TARGET_In;
          if (!full_q) begin
            stack_d[ptr_q] = link;
            ptr_d          = ptr_inc;
            count_d        = count_q + CNT_ONE;
          end else begin
`ifdef CSAI_SEQ_STACK_WRAP_EN
            stack_d[ptr_q] = link;
            ptr_d          = ptr_inc;
`else
            error_d = 1'b1;
`endif
          end
        end
        OP_RET: begin
          if (!empty_q) begin
            pc_d    = stack_q[ptr_dec];
            ptr_d   = ptr_dec;
            count_d = count_q - CNT_ONE;
          end else begin
            pc_d    = link;
            error_d = 1'b1;
          end
        end
        default: pc_d = link;
      endcase
    end
    empty_d = (count_d == '0);
    full_d  = (count_d == DEPTH_C);
  end

  always_ff @(posedge SC_CSAI_SEQ_CLOCK_50 or posedge SC_CSAI_SEQ_RESET_InHigh) begin
    if (SC_CSAI_SEQ_RESET_InHigh) begin
      pc_q    <= RST_W;
      count_q <= '0;
      ptr_q   <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      count_q <= count_d;
      ptr_q   <= ptr_d;
      empty_q <= empty_d;
      full_q  <= full_d;
      error_q <= error_d;
    end
  end

  // Stack contents are meaningless until pushed, so they carry no reset
  always_ff @(posedge SC_CSAI_SEQ_CLOCK_50) begin
    stack_q <= stack_d;
  end

  assign CSAI_SEQ_PC_Out          = pc_q;
  assign CSAI_SEQ_LINK_Out        = link;
  assign CSAI_SEQ_STACK_EMPTY_Out = empty_q;
  assign CSAI_SEQ_STACK_FULL_Out  = full_q;
  assign CSAI_SEQ_ERROR_Out       = error_q;

endmodule

// File: doc/sc_csai_seq.md
Name: sc_csai_seq

Overview:
- Parametrised successor to the single-step address incrementer register: a program-counter sequencer.
- Each clock it selects the next address from one of five sources: increment by STEP, absolute jump, relative branch, call, or return.
- Holds a LIFO return-address stack of STACK_DEPTH entries; supports stall.
- Sits between the control unit and instruction memory address bus of the datapath.

Parameters:
- DATAWIDTH_BUS_CSAI_SEQ, 11, width of all address buses.
- CSAI_SEQ_STEP, 1, increment added for sequential flow and link address.
- CSAI_SEQ_STACK_DEPTH, 4, return stack entries; legal range 2..16.
- CSAI_SEQ_RESET_VECTOR, 0, PC value after reset.

Ports:
- SC_CSAI_SEQ_CLOCK_50  input  1  sole clock; all state changes on the rising edge.
- SC_CSAI_SEQ_RESET_InHigh  input  1  asynchronous, active-high reset.
- CSAI_SEQ_STALL_In  input  1  when 1, all state is held and OP is ignored.
- CSAI_SEQ_OP_In  input  3  000 INC, 001 JMP, 010 BRANCH, 011 CALL, 100 RET; 101–111 behave as INC.
- CSAI_SEQ_TARGET_In  input  DATAWIDTH_BUS_CSAI_SEQ  absolute target (JMP/CALL) or two's-complement displacement (BRANCH).
- CSAI_SEQ_PC_Out  output  DATAWIDTH_BUS_CSAI_SEQ  current PC, registered.
- CSAI_SEQ_LINK_Out  output  DATAWIDTH_BUS_CSAI_SEQ  combinational PC+STEP.
- CSAI_SEQ_STACK_EMPTY_Out  output  1  registered; 1 when stack count = 0.
- CSAI_SEQ_STACK_FULL_Out  output  1  registered; 1 when count = STACK_DEPTH.
- CSAI_SEQ_ERROR_Out  output  1  sticky overflow/underflow flag, registered.

Behaviour:
- Reset (asynchronous, any time including mid-operation):
  - PC = RESET_VECTOR, count = 0, EMPTY = 1, FULL = 0, ERROR = 0.
  - Stack contents are don't-care.
- Latency: OP/TARGET sampled at a rising edge; the resulting PC is visible on PC_Out immediately after that edge (1 cycle).
- Arithmetic: all sums are modulo 2^DATAWIDTH_BUS_CSAI_SEQ; wrap is silent. Example: 0x7FF + 1 = 0x000.
- INC: PC <= PC + STEP.
- JMP: PC <= TARGET.
- BRANCH: PC <= PC + sign-extended TARGET. Example: TARGET 0x7FE = −2.
- CALL, stack not full: push PC+STEP, count+1, PC <= TARGET.
- CALL, stack full: PC <= TARGET, no push, count unchanged, ERROR <= 1.
- RET, stack not empty: PC <= top entry, count−1.
- RET, stack empty: PC <= PC + STEP, count unchanged, ERROR <= 1.
- STALL = 1: PC, stack, count and ERROR all held regardless of OP. LINK_Out still tracks the held PC.
- ERROR is cleared only by reset.
- FULL/EMPTY are derived from the registered count; they update on the same edge as the push/pop.
- There are no simultaneous push and pop: one OP per cycle by construction.

Optional Feature:
- Macro CSAI_SEQ_STACK_WRAP_EN.
- Defined: CALL on a full stack overwrites the oldest entry (circular buffer). PC <= TARGET, count stays STACK_DEPTH, FULL stays 1, ERROR is NOT set. RET-underflow behaviour is unchanged.
- Undefined: full-stack CALL behaviour exactly as in Behaviour (push suppressed, ERROR set).

Test Plan (W=11, STEP=1, DEPTH=4, RESET_VECTOR=0):
- Reset, then 5 INC cycles -> PC 0,1,2,3,4,5; EMPTY=1, ERROR=0. Assert reset mid-sequence -> PC=0 immediately, without waiting for a clock edge.
- From PC=0x7FE: INC, INC -> PC 0x7FF then 0x000. Then BRANCH with TARGET=0x7FE -> PC 0x7FE.
- From PC=0x010: CALL 0x100 -> PC=0x100, EMPTY=0. Then INC. Then RET -> PC=0x011, EMPTY=1, ERROR=0.
- Four CALLs from PCs 0x10, 0x20, 0x30, 0x40 -> FULL=1. A fifth CALL from 0x50 to 0x60 -> PC=0x060, ERROR=1. Then four RETs -> PC 0x041, 0x031, 0x021, 0x011. With CSAI_SEQ_STACK_WRAP_EN: ERROR=0 and the RETs yield 0x051, 0x041, 0x031, 0x021.
- RET on an empty stack at PC=0x005 -> PC=0x006, ERROR=1. ERROR persists through 10 further INC cycles and clears only on reset.
- STALL=1 held 3 cycles with OP=JMP, TARGET=0x2AA at PC=0x003 -> PC stays 0x003 and LINK=0x004. Release STALL -> PC=0x2AA on the next edge.
